// File: rtl/clock_pkg.sv
// Shared definitions for the clock controller: mode encoding, BCD field
// limits and the per-field blank decode.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN    = 2'd0,
      MODE_SET_HH = 2'd1,
      MODE_SET_MM = 2'd2,
      MODE_SET_SS = 2'd3
   } mode_t;

   localparam logic [7:0] BCD_MAX_HH = 8'h23;
   localparam logic [7:0] BCD_MAX_MS = 8'h59;

   // Blank request for a given mode and blink phase: only the field being
   // edited may blank, and only while the phase bit is 1.
   function automatic logic [2:0] blank_mask(input mode_t m, input logic phase);
      logic [2:0] mask;
      mask = 3'b000;
      case (m)
         MODE_SET_HH: mask = {phase, 2'b00};
         MODE_SET_MM: mask = {1'b0, phase, 1'b0};
         MODE_SET_SS: mask = {2'b00, phase};
         default:     mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Button/level inputs and time/display outputs of the clock controller.
interface clock_ctrl_if;
   import clock_pkg::*;

   logic       mode_p;
   logic       inc_p;
   logic       pause;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   mode_t      mode;
   logic [2:0] blank;
   logic       sec_tick;

   modport master (
      output mode_p, inc_p, pause,
      input  hh, mm, ss, mode, blank, sec_tick
   );

   modport slave (
      input  mode_p, inc_p, pause,
      output hh, mm, ss, mode, blank, sec_tick
   );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping from max_val to 00. The carry is
// combinational so the next field can advance on the same edge.
module bcd2_counter (
   input  logic       clk,
   input  logic [7:0] max_val,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);

   // Next BCD value below the wrap point: ones roll 9->0 into the tens digit.
   function automatic logic [7:0] bcd_next(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   assign carry = inc & (value == max_val);

   // Counter register: clear has priority, then wrap or BCD increment.
   always_ff @(posedge clk) begin
      if (clr)
         value <= 8'h00;
      else if (inc) begin
         if (value == max_val) value <= 8'h00;
         else                  value <= bcd_next(value);
      end
   end

endmodule

// File: rtl/clock_ctrl.sv
// 24-hour BCD clock with RUN / SET_HH / SET_MM / SET_SS modes, a seconds
// prescaler, pause, and a blink generator for the field being edited.
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ     = 100,
   parameter int BLINK_HALF = 50
) (
   input  logic       clk,
   input  logic       rst,
   clock_ctrl_if.slave bus
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   mode_t          state, state_nx;
   logic [PW-1:0]  pre;
   logic [BW-1:0]  blink_cnt, blink_nx;
   logic           phase, phase_nx;
   logic           in_set, sel_hh, sel_mm, sel_ss;
   logic           edit, tick_now;
   logic [7:0]     hh_q, mm_q, ss_q;
   logic           ss_carry, mm_carry;
   logic           hh_carry_unused;   // day rollover has no consumer
   logic [2:0]     blank_q;
   logic           sec_tick_q;

   // Mode state register.
   always_ff @(posedge clk) begin
      if (rst) state <= MODE_RUN;
      else     state <= state_nx;
   end

   // Mode sequencing: one step per mode pulse, cycling back to RUN.
   always_comb begin
      state_nx = state;
      if (bus.mode_p) begin
         case (state)
            MODE_RUN:    state_nx = MODE_SET_HH;
            MODE_SET_HH: state_nx = MODE_SET_MM;
            MODE_SET_MM: state_nx = MODE_SET_SS;
            default:     state_nx = MODE_RUN;
         endcase
      end
   end

   // Mode decode used by the datapath.
   always_comb begin
      in_set = (state != MODE_RUN);
      sel_hh = (state == MODE_SET_HH);
      sel_mm = (state == MODE_SET_MM);
      sel_ss = (state == MODE_SET_SS);
   end

   // A mode pulse in the same cycle swallows the increment; RUN ignores it.
   assign edit     = bus.inc_p & ~bus.mode_p & in_set;
   assign tick_now = ~in_set & ~bus.pause & (pre == PW'(CLK_HZ - 1));

   // Seconds prescaler: frozen by pause, held at zero while editing so the
   // first second after returning to RUN is a full one.
   always_ff @(posedge clk) begin
      if (rst || in_set)
         pre <= '0;
      else if (!bus.pause) begin
         if (pre == PW'(CLK_HZ - 1)) pre <= '0;
         else                        pre <= pre + PW'(1);
      end
   end

   // Blink timing: restart visible on mode change or edit, idle in RUN.
   always_comb begin
      blink_nx = blink_cnt;
      phase_nx = phase;
      if (bus.mode_p || edit || !in_set) begin
         blink_nx = '0;
         phase_nx = 1'b0;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
         blink_nx = '0;
         phase_nx = ~phase;
      end else begin
         blink_nx = blink_cnt + BW'(1);
      end
   end

   // Blink state plus registered blank and seconds-tick outputs; blank is
   // decoded from next-state values so it lines up with mode and phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt  <= '0;
         phase      <= 1'b0;
         blank_q    <= 3'b000;
         sec_tick_q <= 1'b0;
      end else begin
         blink_cnt  <= blink_nx;
         phase      <= phase_nx;
         blank_q    <= blank_mask(state_nx, phase_nx);
         sec_tick_q <= tick_now;
      end
   end

   // Running carries ripple ss->mm->hh; edits touch one field with no carry.
   bcd2_counter u_ss (
      .clk     (clk),
      .max_val (BCD_MAX_MS),
      .inc     (tick_now | (edit & sel_ss)),
      .clr     (rst),
      .value   (ss_q),
      .carry   (ss_carry)
   );

   bcd2_counter u_mm (
      .clk     (clk),
      .max_val (BCD_MAX_MS),
      .inc     ((tick_now & ss_carry) | (edit & sel_mm)),
      .clr     (rst),
      .value   (mm_q),
      .carry   (mm_carry)
   );

   bcd2_counter u_hh (
      .clk     (clk),
      .max_val (BCD_MAX_HH),
      .inc     ((tick_now & mm_carry) | (edit & sel_hh)),
      .clr     (rst),
      .value   (hh_q),
      .carry   (hh_carry_unused)
   );

   assign bus.hh       = hh_q;
   assign bus.mm       = mm_q;
   assign bus.ss       = ss_q;
   assign bus.mode     = state;
   assign bus.blank    = blank_q;
   assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a time-of-day model.
module tb_clock_ctrl;

   localparam int CLK_HZ     = 100;
   localparam int BLINK_HALF = 50;

   logic clk;
   logic rst;
   clock_ctrl_if bus ();

   clock_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HALF(BLINK_HALF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: time as seconds of day plus counters in plain ints.
   int m_t, m_md, m_pre, m_bc, m_ph, m_tk;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] tens, ones;
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      return {tens, ones};
   endfunction

   function automatic logic [29:0] model_vec();
      logic [2:0] bl;
      bl = 3'b000;
      if (m_md != 0 && m_ph != 0) bl = 3'b001 << (3 - m_md);
      return {to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
              2'(m_md), bl, 1'(m_tk)};
   endfunction

   function automatic logic [29:0] dut_vec();
      return {bus.hh, bus.mm, bus.ss, 2'(bus.mode), bus.blank, bus.sec_tick};
   endfunction

   task automatic model_step(input logic r, input logic mp, input logic ip, input logic pa);
      int h, mi, s;
      if (r) begin
         m_t = 0; m_md = 0; m_pre = 0; m_bc = 0; m_ph = 0; m_tk = 0;
      end else begin
         m_tk = 0;
         if (m_md == 0) begin
            if (!pa) begin
               if (m_pre == CLK_HZ - 1) begin
                  m_pre = 0;
                  m_t   = (m_t + 1) % 86400;
                  m_tk  = 1;
               end else m_pre++;
            end
         end else m_pre = 0;
         if (mp) begin
            m_md = (m_md + 1) % 4;
            m_bc = 0; m_ph = 0;
         end else if (ip && m_md != 0) begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (m_md == 1) h  = (h + 1) % 24;
            if (m_md == 2) mi = (mi + 1) % 60;
            if (m_md == 3) s  = (s + 1) % 60;
            m_t  = h * 3600 + mi * 60 + s;
            m_bc = 0; m_ph = 0;
         end else if (m_md != 0) begin
            m_bc++;
            if (m_bc == BLINK_HALF) begin
               m_bc = 0;
               m_ph = 1 - m_ph;
            end
         end else begin
            m_bc = 0; m_ph = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic mp, input logic ip, input logic pa);
      rst        = r;
      bus.mode_p = mp;
      bus.inc_p  = ip;
      bus.pause  = pa;
      @(posedge clk);
      model_step(r, mp, ip, pa);
      #1;
   endtask

   task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   typedef struct {
      logic       r, mp, ip, pa;
      int         idle;
      logic [7:0] hh, mm, ss;
      logic [1:0] md;
      logic [2:0] bl;
      logic       tk;
   } vec_t;

   vec_t tbl [21];

   initial begin
      int cnt;
      int ticks;
      logic pa;

      rst = 1'b1; bus.mode_p = 1'b0; bus.inc_p = 1'b0; bus.pause = 1'b0;
      m_t = 0; m_md = 0; m_pre = 0; m_bc = 0; m_ph = 0; m_tk = 0;

      //          r  mp ip pa idle  hh     mm     ss    md    bl      tk
      tbl[0]  = '{1, 0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0};
      tbl[1]  = '{0, 0, 0, 0, 98, 8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0};
      tbl[2]  = '{0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h01, 2'd0, 3'b000, 1'b1};
      tbl[3]  = '{0, 0, 0, 0, 98, 8'h00, 8'h00, 8'h01, 2'd0, 3'b000, 1'b0};
      tbl[4]  = '{0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h02, 2'd0, 3'b000, 1'b1};
      tbl[5]  = '{0, 1, 0, 0, 0,  8'h00, 8'h00, 8'h02, 2'd1, 3'b000, 1'b0};
      tbl[6]  = '{0, 0, 1, 0, 0,  8'h01, 8'h00, 8'h02, 2'd1, 3'b000, 1'b0};
      tbl[7]  = '{0, 0, 0, 0, 49, 8'h01, 8'h00, 8'h02, 2'd1, 3'b100, 1'b0};
      tbl[8]  = '{0, 1, 1, 0, 0,  8'h01, 8'h00, 8'h02, 2'd2, 3'b000, 1'b0};
      tbl[9]  = '{0, 0, 1, 0, 0,  8'h01, 8'h01, 8'h02, 2'd2, 3'b000, 1'b0};
      tbl[10] = '{0, 0, 0, 0, 49, 8'h01, 8'h01, 8'h02, 2'd2, 3'b010, 1'b0};
      tbl[11] = '{0, 0, 0, 0, 49, 8'h01, 8'h01, 8'h02, 2'd2, 3'b000, 1'b0};
      tbl[12] = '{0, 1, 0, 0, 0,  8'h01, 8'h01, 8'h02, 2'd3, 3'b000, 1'b0};
      tbl[13] = '{0, 0, 1, 0, 0,  8'h01, 8'h01, 8'h03, 2'd3, 3'b000, 1'b0};
      tbl[14] = '{0, 0, 0, 1, 49, 8'h01, 8'h01, 8'h03, 2'd3, 3'b001, 1'b0};
      tbl[15] = '{1, 0, 1, 0, 0,  8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0};
      tbl[16] = '{0, 0, 0, 1, 49, 8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0};
      tbl[17] = '{0, 0, 0, 0, 98, 8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0};
      tbl[18] = '{0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h01, 2'd0, 3'b000, 1'b1};
      tbl[19] = '{0, 0, 1, 0, 0,  8'h00, 8'h00, 8'h01, 2'd0, 3'b000, 1'b0};
      tbl[20] = '{1, 1, 0, 0, 0,  8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0};

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].r, tbl[i].mp, tbl[i].ip, tbl[i].pa);
         for (int k = 0; k < tbl[i].idle; k++) step(1'b0, 1'b0, 1'b0, tbl[i].pa);
         chk($sformatf("vec%0d", i), dut_vec(),
             {tbl[i].hh, tbl[i].mm, tbl[i].ss, tbl[i].md, tbl[i].bl, tbl[i].tk});
      end

      // Preload 23:59:59 through the SET modes, then roll over the day.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int k = 0; k < 23; k++) step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      for (int k = 0; k < 59; k++) step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      for (int k = 0; k < 59; k++) step(0, 0, 1, 0);
      step(0, 1, 0, 0);
      chk("preload_235959", dut_vec(), {8'h23, 8'h59, 8'h59, 2'd0, 3'b000, 1'b0});
      ticks = 0;
      for (int k = 0; k < 99; k++) begin
         step(0, 0, 0, 0);
         if (bus.sec_tick) ticks++;
      end
      chk("rollover_wait", {bus.ss, 22'(ticks)}, {8'h59, 22'd0});
      step(0, 0, 0, 0);
      chk("rollover_000000", dut_vec(), {8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b1});

      // SET_MM at 58: three edits wrap 59 -> 00 -> 01 without touching hh.
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      for (int k = 0; k < 58; k++) step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("mm_inc_59", dut_vec(), {8'h00, 8'h59, 8'h00, 2'd2, 3'b000, 1'b0});
      step(0, 0, 1, 0);
      chk("mm_inc_00", dut_vec(), {8'h00, 8'h00, 8'h00, 2'd2, 3'b000, 1'b0});
      step(0, 0, 1, 0);
      chk("mm_inc_01", dut_vec(), {8'h00, 8'h01, 8'h00, 2'd2, 3'b000, 1'b0});
      for (int k = 0; k < 50; k++) step(0, 0, 0, 0);
      chk("mm_blink_on", {29'd0, bus.blank}, {29'd0, 3'b010});
      for (int k = 0; k < 50; k++) step(0, 0, 0, 0);
      chk("mm_blink_off", {29'd0, bus.blank}, {29'd0, 3'b000});

      // Pause at prescaler 40 for 250 cycles; next tick 60 cycles after release.
      step(1, 0, 0, 0);
      for (int k = 0; k < 40; k++) step(0, 0, 0, 0);
      for (int k = 0; k < 250; k++) step(0, 0, 0, 1);
      chk("pause_hold", dut_vec(), {8'h00, 8'h00, 8'h00, 2'd0, 3'b000, 1'b0});
      cnt = 0;
      do begin
         step(0, 0, 0, 0);
         cnt++;
      end while (!bus.sec_tick && cnt < 200);
      chk("pause_release_latency", 30'(cnt), 30'd60);

      // Randomized run against the reference model.
      step(1, 0, 0, 0);
      pa = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(49) == 0) pa = ~pa;
         step(($urandom_range(399) == 0), ($urandom_range(23) == 0),
              ($urandom_range(5) == 0), pa);
         chk($sformatf("rand%0d", k), dut_vec(), model_vec());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
